// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_e;

  localparam int N_DEFAULT = 4;
  // Skewed feed of an N x N pair lasts 4N-2 cycles.
  localparam int FEED_LEN  = 4 * N_DEFAULT - 2;
  localparam int IDX_W     = $clog2(N_DEFAULT);

  function automatic int feed_len(input int n);
    return 4 * n - 2;
  endfunction

  // Row index width; never below one bit so N=1 still builds.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// Skew generator: lane i gets A[i][t-i] and B[t-i][i], zero outside range.
module systolic_skew #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int TW     = 4
) (
  input  logic                             en,
  input  logic [TW-1:0]                    t,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  b,
  output logic [N-1:0][DATA_W-1:0]         a_in,
  output logic [N-1:0][DATA_W-1:0]         b_in
);

  // Select the diagonal element k = t - lane for every lane.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (en && (int'(t) == i + k)) begin
          a_in[i] = a[i][k];
          b_in[i] = b[k][i];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: stores A/B, streams skewed operands, drains and
// returns C row by row. Optional cycle counter under SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int DRAIN_CYC = 4 * N,
  localparam int IW       = (N == N_DEFAULT) ? IDX_W : idx_w(N)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            a_wr_en,
  input  logic [IW-1:0]                   a_wr_row,
  input  logic [N*DATA_W-1:0]             a_wr_data,
  input  logic                            b_wr_en,
  input  logic [IW-1:0]                   b_wr_row,
  input  logic [N*DATA_W-1:0]             b_wr_data,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [N-1:0][DATA_W-1:0]        A_in,
  output logic [N-1:0][DATA_W-1:0]        B_in,
  output logic                            arr_clr,
  input  logic [N-1:0][N-1:0][ACC_W-1:0]  C,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [IW-1:0]                   res_row,
  output logic [N*ACC_W-1:0]              res_data
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]                     perf_cycles
`endif
);

  localparam int FEED_N  = (N == N_DEFAULT) ? FEED_LEN : feed_len(N);
  localparam int CNT_MAX = (FEED_N > DRAIN_CYC) ? FEED_N : DRAIN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                    row_q, row_d;
  logic [N-1:0][N-1:0][DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0][N-1:0][ACC_W-1:0]   res_q, res_d;
  logic [N-1:0][DATA_W-1:0]         a_in_q, a_in_d, b_in_q, b_in_d;
  logic                             last_feed, last_drain, last_row;

  assign last_feed  = (cnt_q == CW'(FEED_N - 1));
  assign last_drain = (cnt_q == CW'(DRAIN_CYC - 1));
  assign last_row   = (row_q == IW'(N - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED:  if (last_feed) state_d = S_DRAIN;
      S_DRAIN: if (last_drain) state_d = S_OUT;
      S_OUT:   if (res_ready && last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; result path is forced to zero outside OUT.
  always_comb begin
    busy      = (state_q != S_IDLE);
    arr_clr   = (state_q == S_CLEAR);
    res_valid = (state_q == S_OUT);
    done      = res_valid && res_ready && last_row;
    res_row   = res_valid ? row_q : '0;
    res_data  = res_valid ? res_q[row_q] : '0;
    A_in      = a_in_q;
    B_in      = b_in_q;
  end

  // Operand registers load the value for the cycle being entered, so
  // A_in/B_in line up with FEED cycle t while staying registered.
  systolic_skew #(.N(N), .DATA_W(DATA_W), .TW(CW)) u_skew (
    .en   (state_d == S_FEED),
    .t    (cnt_d),
    .a    (a_q),
    .b    (b_q),
    .a_in (a_in_d),
    .b_in (b_in_d)
  );

  // Counter, row index, operand stores and result capture.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == S_FEED || state_q == S_DRAIN))
      cnt_d = cnt_q + CW'(1);

    row_d = row_q;
    if (state_q == S_OUT && res_ready)
      row_d = last_row ? '0 : row_q + IW'(1);

    a_d = a_q;
    b_d = b_q;
    if (state_q == S_IDLE) begin
      if (a_wr_en) a_d[a_wr_row] = a_wr_data;
      if (b_wr_en) b_d[b_wr_row] = b_wr_data;
    end

    res_d = res_q;
    if (state_q == S_DRAIN && last_drain)
      res_d = C;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      row_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      a_in_q <= '0;
      b_in_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      a_in_q <= a_in_d;
      b_in_q <= b_in_d;
    end
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts every non-IDLE cycle of a job; restarts on an accepted start.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start) perf_d = '0;
    else if (state_q != S_IDLE)     perf_d = perf_q + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with a behavioural PE array model.
module tb_systolic_feeder;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DRAIN = 4 * N;
  localparam int IW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_wr_en = 1'b0, b_wr_en = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic [IW-1:0] a_wr_row = '0, b_wr_row = '0;
  logic [N*DW-1:0] a_wr_data = '0, b_wr_data = '0;
  logic busy, done, arr_clr, res_valid;
  logic [N-1:0][DW-1:0] A_in, B_in;
  logic [N-1:0][N-1:0][AW-1:0] C;
  logic [IW-1:0] res_row;
  logic [N*AW-1:0] res_data;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_cycles;
`endif

  systolic_feeder #(.N(N), .DATA_W(DW), .ACC_W(AW), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_data(b_wr_data),
    .start(start), .busy(busy), .done(done),
    .A_in(A_in), .B_in(B_in), .arr_clr(arr_clr), .C(C),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_data(res_data)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  int ma[N][N], mb[N][N];
  bit force_low = 1'b0, rand_rdy = 1'b0;

  typedef struct { int row; logic [N*AW-1:0] data; } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output-stationary PE array: a flows right, b flows down, acc += a*b.
  logic [DW-1:0] pa[N][N], pb[N][N], aw_[N][N], bw_[N][N];
  logic [AW-1:0] acc[N][N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      aw_[i][0] = A_in[i];
      bw_[0][i] = B_in[i];
      for (int j = 1; j < N; j++) begin
        aw_[i][j] = pa[i][j-1];
        bw_[j][i] = pb[j-1][i];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        C[i][j] = acc[i][j];
  end
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pa[i][j] <= aw_[i][j];
        pb[i][j] <= bw_[i][j];
        acc[i][j] <= arr_clr ? '0 : acc[i][j] + AW'(aw_[i][j]) * AW'(bw_[i][j]);
      end
  end

  // Monitor: check done timing and pop the scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("done_timing", done, res_valid && res_ready && res_row == IW'(N-1));
      if (done) done_cnt++;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) check("sb_nonempty", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          check("res_row", res_row, e.row);
          check("res_data", res_data, e.data);
        end
      end
    end
  end

  // Ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      res_ready = force_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N*AW-1:0] exp_row(input int i);
    logic [N*AW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
      r[j*AW +: AW] = AW'(s);
    end
    return r;
  endfunction

  function automatic int skew_a(input int t, input int i);
    return (t - i >= 0 && t - i < N) ? ma[i][t-i] : 0;
  endfunction

  function automatic int skew_b(input int t, input int j);
    return (t - j >= 0 && t - j < N) ? mb[t-j][j] : 0;
  endfunction

  task automatic load(input int a[N][N], input int b[N][N]);
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      a_wr_en = 1'b1; b_wr_en = 1'b1;
      a_wr_row = IW'(i); b_wr_row = IW'(i);
      for (int k = 0; k < N; k++) begin
        a_wr_data[k*DW +: DW] = DW'(a[i][k]);
        b_wr_data[k*DW +: DW] = DW'(b[i][k]);
        ma[i][k] = a[i][k] & 255;
        mb[i][k] = b[i][k] & 255;
      end
    end
    @(posedge clk); #1;
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.row = i; e.data = exp_row(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0 plain, 1 skew check, 2 start/write during FEED, 3 cycle count
  task automatic run_job(input int mode);
    int cyc;
    bit seen;
    push_expected();
    pulse_start();
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("arr_clr_clear", arr_clr, 1);
      if (cyc == 2) check("arr_clr_feed", arr_clr, 0);
      if (mode == 1 && cyc >= 2 && cyc <= 4*N - 1)
        for (int i = 0; i < N; i++) begin
          check("skew_A_in", A_in[i], skew_a(cyc - 2, i));
          check("skew_B_in", B_in[i], skew_b(cyc - 2, i));
        end
      if (mode == 1 && cyc == 4*N) check("drain_zero", {A_in, B_in}, 0);
      if (mode == 2 && cyc == 3) begin
        start = 1'b1; a_wr_en = 1'b1; a_wr_row = '0; a_wr_data = '1;
      end
      if (mode == 2 && cyc == 4) begin
        check("busy_after_restart", busy, 1);
        start = 1'b0; a_wr_en = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check("job_done_seen", seen, 1);
    if (mode == 3) check("job_cycles", cyc, 1 + (4*N - 2) + DRAIN + N);
    @(posedge clk); #1;
    check("sb_drained", sb_q.size(), 0);
    check("idle_after_job", busy, 0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    if (mode == 3) check("perf_cycles", perf_cycles, 1 + (4*N - 2) + DRAIN + N);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_arr_clr"}, arr_clr, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_operands"}, {A_in, B_in}, 0);
    check({tag, "_res_row"}, res_row, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  int ra[N][N], rb[N][N];

  initial begin
    int cyc, dcnt;
    logic [N*AW-1:0] d0;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Sparse known product, ready held high, cycle count checked.
    ra = '{'{1,0,0,4}, '{0,2,0,8}, '{0,0,5,0}, '{0,0,3,4}};
    rb = '{'{0,7,6,0}, '{8,0,0,0}, '{0,0,6,0}, '{0,9,4,0}};
    load(ra, rb);
    run_job(3);

    // A = 1..16, B = identity: result equals A; full skew check.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ra[i][j] = i*N + j + 1;
        rb[i][j] = (i == j) ? 1 : 0;
      end
    load(ra, rb);
    run_job(1);

    // Backpressure: hold ready low five cycles inside OUT.
    push_expected();
    force_low = 1'b1;
    @(posedge clk); #1;
    dcnt = done_cnt;
    pulse_start();
    cyc = 0;
    while (!res_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check("bp_reached_out", res_valid, 1);
    d0 = res_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_row", res_row, 0);
      check("bp_data", res_data, d0);
    end
    check("bp_no_done", done_cnt, dcnt);
    force_low = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin @(negedge clk); cyc++; end
    check("bp_finished", busy, 0);
    check("bp_sb_drained", sb_q.size(), 0);

    // Random matrices with random backpressure.
    rand_rdy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ra[i][j] = int'($urandom_range(0, 255));
          rb[i][j] = int'($urandom_range(0, 255));
        end
      load(ra, rb);
      run_job(0);
    end

    // Start and A write during FEED ignored; rerun without reload matches.
    run_job(2);
    run_job(0);
    rand_rdy = 1'b0;

    // Reset inside DRAIN aborts with no done, clears the stores.
    dcnt = done_cnt;
    pulse_start();
    repeat (1 + (4*N - 2) + 3) @(negedge clk);
    check("abort_in_drain", busy, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("abort");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_stays_idle", busy, 0);
    check("abort_no_done", done_cnt, dcnt);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    run_job(0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ra[i][j] = int'($urandom_range(0, 255));
        rb[i][j] = int'($urandom_range(0, 255));
      end
    load(ra, rb);
    run_job(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
